// File: rtl/freq_pkg.sv
// Shared definitions for the frequency meter: controller states, default
// counter width and the reference clock rate used by the calculation stage.
package freq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        GATE,
        CLOSE,
        DONE
    } state_e;

    localparam int unsigned CW_DEF = 27;
    localparam int unsigned CLK_HZ = 50000000;

endpackage

// File: rtl/freq_gate_edge.sv
// Two-flop synchroniser and registered rising-edge detector for the
// asynchronous measured signal.
module edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);
    logic       sync1_q, sync1_d;
    logic       sync2_q, sync2_d;
    logic       prev_q,  prev_d;
    logic       rise_q,  rise_d;
    logic [2:0] fill_q,  fill_d;

    always_comb begin
        sync1_d = din;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        fill_d  = {fill_q[1:0], 1'b1};
        // fill_q[2] means prev_q holds a real post-reset sample, so a level
        // that was already high at reset release is never reported as a rise.
        rise_d  = sync2_q & ~prev_q & fill_q[2];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            rise_q  <= 1'b0;
            fill_q  <= 3'b000;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
            rise_q  <= rise_d;
            fill_q  <= fill_d;
        end
    end

    assign rise = rise_q;

endmodule

// File: rtl/freq_gate_ctrl.sv
// Equal-precision gate controller: opens on a signal edge, holds at least
// GATE_CYC clocks, closes on the next edge and reports N and M.
module freq_gate_ctrl
    import freq_pkg::*;
#(
    parameter int unsigned CW          = CW_DEF,
    parameter int unsigned GATE_CYC    = 50000000,
    parameter int unsigned TIMEOUT_CYC = 50000000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sig_in,
    input  logic          start,
    input  logic          cont,
    output logic [CW-1:0] sig_cnt,
    output logic [CW-1:0] ref_cnt,
    output logic          valid,
    output logic          no_sig,
    output logic          busy
);
    localparam logic [CW-1:0] GATE_V    = CW'(GATE_CYC);
    localparam logic [CW-1:0] TIMEOUT_V = CW'(TIMEOUT_CYC);

    if ((64'(GATE_CYC) + 64'(TIMEOUT_CYC)) >= (64'd1 << CW)) begin : g_width_chk
        $error("freq_gate_ctrl: GATE_CYC + TIMEOUT_CYC must be below 2**CW");
    end

    state_e        state_q, state_d;
    logic [CW-1:0] n_q, n_d;
    logic [CW-1:0] m_q, m_d;
    logic [CW-1:0] wait_q, wait_d;
    logic [CW-1:0] sig_cnt_q, sig_cnt_d;
    logic [CW-1:0] ref_cnt_q, ref_cnt_d;
    logic          valid_q, valid_d;
    logic          no_sig_q, no_sig_d;
    logic          busy_q, busy_d;
    logic          closed;
    logic          timed_out;
    logic          sig_edge;

    edge_sync u_edge_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (sig_in),
        .rise (sig_edge)
    );

    always_comb begin
        state_d   = state_q;
        n_d       = n_q;
        m_d       = m_q;
        wait_d    = wait_q;
        closed    = 1'b0;
        timed_out = 1'b0;

        case (state_q)
            IDLE: begin
                wait_d = '0;
                if (start || cont) state_d = ARM;
            end
            ARM: begin
                // The opening edge only zeroes the counters; it is not counted.
                if (sig_edge) begin
                    n_d     = '0;
                    m_d     = '0;
                    state_d = GATE;
                end else if (wait_q == TIMEOUT_V) begin
                    timed_out = 1'b1;
                    state_d   = DONE;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            GATE: begin
                m_d = m_q + 1'b1;
                if (sig_edge) n_d = n_q + 1'b1;
                if (m_d >= GATE_V) begin
                    if (sig_edge) begin
                        closed  = 1'b1;
                        state_d = DONE;
                    end else begin
                        wait_d  = '0;
                        state_d = CLOSE;
                    end
                end
            end
            CLOSE: begin
                if (sig_edge) begin
                    m_d     = m_q + 1'b1;
                    n_d     = n_q + 1'b1;
                    closed  = 1'b1;
                    state_d = DONE;
                end else if (wait_q == TIMEOUT_V) begin
                    timed_out = 1'b1;
                    state_d   = DONE;
                end else begin
                    m_d    = m_q + 1'b1;
                    wait_d = wait_q + 1'b1;
                end
            end
            DONE: begin
                wait_d  = '0;
                state_d = cont ? ARM : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Results are loaded on the transition into DONE so they appear with valid.
    always_comb begin
        sig_cnt_d = sig_cnt_q;
        ref_cnt_d = ref_cnt_q;
        no_sig_d  = no_sig_q;
        if (closed) begin
            sig_cnt_d = n_d;
            ref_cnt_d = m_d;
            no_sig_d  = 1'b0;
        end else if (timed_out) begin
            sig_cnt_d = '0;
            ref_cnt_d = '0;
            no_sig_d  = 1'b1;
        end
        valid_d = closed | timed_out;
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            n_q       <= '0;
            m_q       <= '0;
            wait_q    <= '0;
            sig_cnt_q <= '0;
            ref_cnt_q <= '0;
            valid_q   <= 1'b0;
            no_sig_q  <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            n_q       <= n_d;
            m_q       <= m_d;
            wait_q    <= wait_d;
            sig_cnt_q <= sig_cnt_d;
            ref_cnt_q <= ref_cnt_d;
            valid_q   <= valid_d;
            no_sig_q  <= no_sig_d;
            busy_q    <= busy_d;
        end
    end

    assign sig_cnt = sig_cnt_q;
    assign ref_cnt = ref_cnt_q;
    assign valid   = valid_q;
    assign no_sig  = no_sig_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_freq_gate_ctrl.sv
// Directed bench for freq_gate_ctrl with a short gate (1000) and timeout (5000).
module tb_freq_gate_ctrl;
    import freq_pkg::*;

    localparam int GATE = 1000;
    localparam int TO   = 5000;

    logic        clk;
    logic        rst;
    logic        sig_in;
    logic        start;
    logic        cont;
    logic [15:0] sig_cnt;
    logic [15:0] ref_cnt;
    logic        valid;
    logic        no_sig;
    logic        busy;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    int          nvalid   = 0;
    int          v_cyc    = 0;
    int          v_rise   = 0;
    int          rise_cyc = 0;
    logic [15:0] v_sig    = '0;
    logic [15:0] v_ref    = '0;
    logic        v_no     = 1'b0;
    bit          sig_run  = 1'b0;
    int          sig_period = 47;
    int          sig_half   = 23;
    int          sig_ph     = 0;
    int          close_cnt  = 0;

    freq_gate_ctrl #(.CW(16), .GATE_CYC(GATE), .TIMEOUT_CYC(TO)) dut (
        .clk     (clk),
        .rst     (rst),
        .sig_in  (sig_in),
        .start   (start),
        .cont    (cont),
        .sig_cnt (sig_cnt),
        .ref_cnt (ref_cnt),
        .valid   (valid),
        .no_sig  (no_sig),
        .busy    (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (dut.state_q == CLOSE) close_cnt <= close_cnt + 1;
    end

    // One clock: sample outputs just after the edge, then drive the next sig_in level.
    task automatic tick();
        logic nxt;
        @(posedge clk);
        #1;
        cyc++;
        if (valid === 1'b1) begin
            nvalid++;
            v_sig  = sig_cnt;
            v_ref  = ref_cnt;
            v_no   = no_sig;
            v_cyc  = cyc;
            v_rise = rise_cyc;
        end
        if (sig_run) begin
            nxt = (sig_ph < sig_half);
            if (nxt && !sig_in) rise_cyc = cyc;
            sig_in = nxt;
            sig_ph = (sig_ph + 1 == sig_period) ? 0 : sig_ph + 1;
        end
    endtask

    task automatic gen_start(input int period);
        sig_period = period;
        sig_half   = period / 2;
        sig_ph     = 0;
        sig_run    = 1'b1;
    endtask

    task automatic wait_valid(input int max_cyc, output bit got);
        int n0;
        n0  = nvalid;
        got = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            tick();
            if (nvalid != n0) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int start_cyc;
        bit got;
        rst = 1'b1; sig_in = 1'b1; start = 1'b0; cont = 1'b0; sig_run = 1'b0;
        repeat (3) tick();
        n_checks++; if (sig_cnt !== 16'd0) $display("FAIL rst_sig_cnt: got %0d want 0", sig_cnt); else n_pass++;
        n_checks++; if (ref_cnt !== 16'd0) $display("FAIL rst_ref_cnt: got %0d want 0", ref_cnt); else n_pass++;
        n_checks++; if (valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", valid); else n_pass++;
        n_checks++; if (no_sig !== 1'b0) $display("FAIL rst_no_sig: got %b want 0", no_sig); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else n_pass++;
        // sig_in stays high across release: no opening edge may be seen.
        rst = 1'b0; start = 1'b1; start_cyc = cyc;
        tick();
        start = 1'b0;
        n_checks++; if (busy !== 1'b1) $display("FAIL hi_busy_after_start: got %b want 1", busy); else n_pass++;
        wait_valid(TO + 100, got);
        n_checks++; if (!got) $display("FAIL hi_valid_seen: got none want one"); else n_pass++;
        n_checks++; if (v_cyc - start_cyc != TO + 2) $display("FAIL hi_timeout_latency: got %0d want %0d", v_cyc - start_cyc, TO + 2); else n_pass++;
        n_checks++; if (v_no !== 1'b1) $display("FAIL hi_no_sig: got %b want 1", v_no); else n_pass++;
    endtask

    task automatic test_no_signal();
        int start_cyc;
        bit got;
        sig_run = 1'b0; sig_in = 1'b0;
        repeat (10) tick();
        start = 1'b1; start_cyc = cyc;
        tick();
        start = 1'b0;
        wait_valid(TO + 100, got);
        n_checks++; if (!got) $display("FAIL nosig_valid_seen: got none want one"); else n_pass++;
        n_checks++; if (v_cyc - start_cyc != TO + 2) $display("FAIL nosig_latency: got %0d want %0d", v_cyc - start_cyc, TO + 2); else n_pass++;
        n_checks++; if (v_sig !== 16'd0) $display("FAIL nosig_sig_cnt: got %0d want 0", v_sig); else n_pass++;
        n_checks++; if (v_ref !== 16'd0) $display("FAIL nosig_ref_cnt: got %0d want 0", v_ref); else n_pass++;
        n_checks++; if (v_no !== 1'b1) $display("FAIL nosig_flag: got %b want 1", v_no); else n_pass++;
        tick();
        n_checks++; if (busy !== 1'b0) $display("FAIL nosig_busy_after: got %b want 0", busy); else n_pass++;
        n_checks++; if (valid !== 1'b0) $display("FAIL nosig_valid_width: got %b want 0", valid); else n_pass++;
    endtask

    task automatic test_basic();
        bit got;
        gen_start(47);
        repeat (5) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        n_checks++; if (busy !== 1'b1) $display("FAIL basic_busy: got %b want 1", busy); else n_pass++;
        wait_valid(3000, got);
        n_checks++; if (!got) $display("FAIL basic_valid_seen: got none want one"); else n_pass++;
        n_checks++; if (v_sig !== 16'd22) $display("FAIL basic_sig_cnt: got %0d want 22", v_sig); else n_pass++;
        n_checks++; if (v_ref !== 16'd1034) $display("FAIL basic_ref_cnt: got %0d want 1034", v_ref); else n_pass++;
        n_checks++; if (v_no !== 1'b0) $display("FAIL basic_no_sig: got %b want 0", v_no); else n_pass++;
        n_checks++; if (v_cyc - v_rise != 4) $display("FAIL basic_latency: got %0d want 4", v_cyc - v_rise); else n_pass++;
        tick();
        n_checks++; if (valid !== 1'b0) $display("FAIL basic_valid_width: got %b want 0", valid); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL basic_busy_after: got %b want 0", busy); else n_pass++;
        repeat (20) tick();
        n_checks++; if (sig_cnt !== 16'd22) $display("FAIL basic_hold: got %0d want 22", sig_cnt); else n_pass++;
    endtask

    task automatic test_boundary();
        bit got;
        int close0;
        gen_start(50);
        repeat (5) tick();
        close0 = close_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_valid(3000, got);
        n_checks++; if (!got) $display("FAIL bnd_valid_seen: got none want one"); else n_pass++;
        n_checks++; if (v_sig !== 16'd20) $display("FAIL bnd_sig_cnt: got %0d want 20", v_sig); else n_pass++;
        n_checks++; if (v_ref !== 16'd1000) $display("FAIL bnd_ref_cnt: got %0d want 1000", v_ref); else n_pass++;
        n_checks++; if (close_cnt != close0) $display("FAIL bnd_close_cycles: got %0d want 0", close_cnt - close0); else n_pass++;
    endtask

    task automatic test_stop_mid_gate();
        bit got;
        gen_start(47);
        repeat (5) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (650) tick();
        sig_run = 1'b0;
        wait_valid(TO + 2000, got);
        n_checks++; if (!got) $display("FAIL stop_valid_seen: got none want one"); else n_pass++;
        n_checks++; if (v_no !== 1'b1) $display("FAIL stop_no_sig: got %b want 1", v_no); else n_pass++;
        n_checks++; if (v_sig !== 16'd0) $display("FAIL stop_sig_cnt: got %0d want 0", v_sig); else n_pass++;
        n_checks++; if (v_ref !== 16'd0) $display("FAIL stop_ref_cnt: got %0d want 0", v_ref); else n_pass++;
    endtask

    task automatic test_continuous();
        bit got;
        int c1;
        int n3;
        sig_in = 1'b0;
        gen_start(47);
        repeat (5) tick();
        cont = 1'b1;
        wait_valid(3000, got);
        n_checks++; if (!got || v_sig !== 16'd22 || v_ref !== 16'd1034 || v_no !== 1'b0)
            $display("FAIL cont_first: got %0d/%0d/%b want 22/1034/0", v_sig, v_ref, v_no); else n_pass++;
        c1 = v_cyc;
        repeat (100) tick();
        n_checks++; if (busy !== 1'b1) $display("FAIL cont_busy: got %b want 1", busy); else n_pass++;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_valid(3000, got);
        n_checks++; if (!got || v_sig !== 16'd22 || v_ref !== 16'd1034)
            $display("FAIL cont_second: got %0d/%0d want 22/1034", v_sig, v_ref); else n_pass++;
        n_checks++; if (v_cyc - c1 != 1081) $display("FAIL cont_spacing: got %0d want 1081", v_cyc - c1); else n_pass++;
        repeat (100) tick();
        cont = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_valid(3000, got);
        n_checks++; if (!got || v_sig !== 16'd22 || v_ref !== 16'd1034)
            $display("FAIL cont_third: got %0d/%0d want 22/1034", v_sig, v_ref); else n_pass++;
        n3 = nvalid;
        repeat (2500) tick();
        n_checks++; if (nvalid != n3) $display("FAIL cont_extra_valid: got %0d want 0", nvalid - n3); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL cont_idle_busy: got %b want 0", busy); else n_pass++;
    endtask

    task automatic test_reset_mid_gate();
        bit got;
        int n0;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (350) tick();
        rst = 1'b1;
        #1;
        n_checks++; if (sig_cnt !== 16'd0) $display("FAIL rmid_sig_cnt: got %0d want 0", sig_cnt); else n_pass++;
        n_checks++; if (ref_cnt !== 16'd0) $display("FAIL rmid_ref_cnt: got %0d want 0", ref_cnt); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL rmid_busy: got %b want 0", busy); else n_pass++;
        n0 = nvalid;
        repeat (3) tick();
        rst = 1'b0;
        repeat (20) tick();
        n_checks++; if (nvalid != n0 || busy !== 1'b0) $display("FAIL rmid_quiet: got %0d valids busy %b want 0 valids busy 0", nvalid - n0, busy); else n_pass++;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_valid(3000, got);
        n_checks++; if (!got) $display("FAIL rmid_valid_seen: got none want one"); else n_pass++;
        n_checks++; if (v_sig !== 16'd22) $display("FAIL rmid_sig_cnt_after: got %0d want 22", v_sig); else n_pass++;
        n_checks++; if (v_ref !== 16'd1034) $display("FAIL rmid_ref_cnt_after: got %0d want 1034", v_ref); else n_pass++;
    endtask

    initial begin
        rst = 1'b1; sig_in = 1'b0; start = 1'b0; cont = 1'b0;
        test_reset();
        test_no_signal();
        test_basic();
        test_boundary();
        test_stop_mid_gate();
        test_continuous();
        test_reset_mid_gate();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
